rob_multi_wb: RTL and testbench

Parametrised reorder buffer for the out-of-order core. It allocates entries in program order from the issue stage and accepts out-of-order completions on `NWB` independent writeback ports. It retires one entry per cycle to the ARF/free-list under back-pressure, and flushes itself when an excepting instruction reaches the head. It replaces the fixed 16-entry, two-port, halt-on-exception ROB and sits between rename/issue and ARF commit.

---
 rtl/rob_multi_wb.sv | 167 ++++++++++++++++
 tb/tb_rob_multi_wb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_wb.sv
// rob_multi_wb: parametrised reorder buffer with NWB out-of-order writeback ports.
//   Entries are allocated in program order at the tail, completed out of order on
//   any writeback port, and retired in order from the head (one per cycle).
//   An excepting entry reaching the head flushes the whole buffer.
// Ports:
//   clk, rst (async, active-low)
//   alloc_*   : issue-side allocation handshake and fields, alloc_tag_ROB = tail index
//   wb_*      : NWB packed completion ports (index, result tag, exception)
//   retire_*  : head entry fields and commit handshake
//   flush_in  : external flush; flush_out : one-cycle pulse after an exception flush
//   count, full, empty : occupancy status
module rob_multi_wb #(
  parameter int DEPTH = 16,
  parameter int ARF_W = 3,
  parameter int PRF_W = 5,
  parameter int NWB   = 2,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic                 alloc_RegWr,
  input  logic [ARF_W-1:0]     alloc_Rw,
  input  logic [PRF_W-1:0]     alloc_tag_Rw_old,
  output logic [IW-1:0]        alloc_tag_ROB,
  input  logic [NWB-1:0]       wb_valid,
  input  logic [NWB*IW-1:0]    wb_tag_ROB,
  input  logic [NWB*PRF_W-1:0] wb_tag_PRF,
  input  logic [NWB-1:0]       wb_exc,
  output logic                 retire_valid,
  input  logic                 retire_ready,
  output logic                 retire_RegWr,
  output logic [ARF_W-1:0]     retire_Rw,
  output logic [PRF_W-1:0]     retire_tag_PRF,
  output logic [PRF_W-1:0]     retire_tag_Rw_old,
  input  logic                 flush_in,
  output logic                 flush_out,
  output logic [IW:0]          count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [IW:0] PTR_ONE = 1;

  // Control state (reset)
  logic [DEPTH-1:0] valid_q, done_q, exc_q;
  logic [IW:0]      head_q, tail_q;

  // Entry payload (not reset; qualified by valid_q on the way out)
  logic             regwr_q  [DEPTH];
  logic [ARF_W-1:0] rw_q     [DEPTH];
  logic [PRF_W-1:0] prf_q    [DEPTH];
  logic [PRF_W-1:0] old_q    [DEPTH];

  logic [IW-1:0] hidx, tidx;
  logic          head_exc, do_flush, do_alloc, do_retire;

  // Per-entry merged writeback: any port hit, OR of exceptions, highest port's tag
  logic [DEPTH-1:0] wb_hit, wb_exc_set;
  logic [PRF_W-1:0] wb_tag [DEPTH];

  assign hidx = head_q[IW-1:0];
  assign tidx = tail_q[IW-1:0];

  assign empty = (head_q == tail_q);
  assign full  = (head_q[IW] != tail_q[IW]) && (head_q[IW-1:0] == tail_q[IW-1:0]);
  assign count = tail_q - head_q;

  assign alloc_ready   = !full;
  assign alloc_tag_ROB = tidx;

  assign head_exc     = valid_q[hidx] && done_q[hidx] && exc_q[hidx];
  assign retire_valid = valid_q[hidx] && done_q[hidx] && !exc_q[hidx];

  assign retire_RegWr      = valid_q[hidx] ? regwr_q[hidx] : 1'b0;
  assign retire_Rw         = valid_q[hidx] ? rw_q[hidx]    : '0;
  assign retire_tag_PRF    = valid_q[hidx] ? prf_q[hidx]   : '0;
  assign retire_tag_Rw_old = valid_q[hidx] ? old_q[hidx]   : '0;

  assign do_flush  = flush_in || head_exc;
  assign do_alloc  = alloc_valid && !full && !do_flush;
  assign do_retire = retire_valid && retire_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wb_hit[i]     = 1'b0;
      wb_exc_set[i] = 1'b0;
      wb_tag[i]     = '0;
      // Ascending port order: a later (higher) port overrides the tag
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid[k] && valid_q[i] && (wb_tag_ROB[k*IW +: IW] == IW'(i))) begin
          wb_hit[i]     = 1'b1;
          wb_exc_set[i] = wb_exc_set[i] | wb_exc[k];
          wb_tag[i]     = wb_tag_PRF[k*PRF_W +: PRF_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      done_q    <= '0;
      exc_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      flush_out <= 1'b0;
    end else begin
      flush_out <= head_exc;
      if (do_flush) begin
        valid_q <= '0;
        done_q  <= '0;
        exc_q   <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_hit[i]) begin
            done_q[i] <= 1'b1;
            exc_q[i]  <= exc_q[i] | wb_exc_set[i];
          end
        end
        // The tail slot is never valid when not full, so it cannot collide with a writeback
        if (do_alloc) begin
          valid_q[tidx] <= 1'b1;
          done_q[tidx]  <= 1'b0;
          exc_q[tidx]   <= 1'b0;
          tail_q        <= tail_q + PTR_ONE;
        end
        // Retire is applied last so it overrides a same-cycle writeback to the head
        if (do_retire) begin
          valid_q[hidx] <= 1'b0;
          done_q[hidx]  <= 1'b0;
          exc_q[hidx]   <= 1'b0;
          head_q        <= head_q + PTR_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_flush) begin
        regwr_q[i] <= 1'b0;
        rw_q[i]    <= '0;
        prf_q[i]   <= '0;
        old_q[i]   <= '0;
      end else begin
        if (wb_hit[i]) prf_q[i] <= wb_tag[i];
        if (do_alloc && (tidx == IW'(i))) begin
          regwr_q[i] <= alloc_RegWr;
          rw_q[i]    <= alloc_Rw;
          prf_q[i]   <= '0;
          old_q[i]   <= alloc_tag_Rw_old;
        end
        if (do_retire && (hidx == IW'(i))) begin
          regwr_q[i] <= 1'b0;
          rw_q[i]    <= '0;
          prf_q[i]   <= '0;
          old_q[i]   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_wb.sv
// tb_rob_multi_wb: self-checking bench for rob_multi_wb (DEPTH=16, NWB=2).
//   Allocations push the expected retire record to a queue; every retire pops it and
//   compares Rw/RegWr/old tag, and the result tag recorded when the bench wrote it back.
module tb_rob_multi_wb;
  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int ARF_W = 3;
  localparam int PRF_W = 5;
  localparam int NWB   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 alloc_valid, alloc_ready, alloc_RegWr;
  logic [ARF_W-1:0]     alloc_Rw;
  logic [PRF_W-1:0]     alloc_tag_Rw_old;
  logic [IW-1:0]        alloc_tag_ROB;
  logic [NWB-1:0]       wb_valid, wb_exc;
  logic [NWB*IW-1:0]    wb_tag_ROB;
  logic [NWB*PRF_W-1:0] wb_tag_PRF;
  logic                 retire_valid, retire_ready, retire_RegWr;
  logic [ARF_W-1:0]     retire_Rw;
  logic [PRF_W-1:0]     retire_tag_PRF, retire_tag_Rw_old;
  logic                 flush_in, flush_out;
  logic [IW:0]          count;
  logic                 full, empty;

  rob_multi_wb #(.DEPTH(DEPTH), .ARF_W(ARF_W), .PRF_W(PRF_W), .NWB(NWB)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_RegWr(alloc_RegWr),
    .alloc_Rw(alloc_Rw), .alloc_tag_Rw_old(alloc_tag_Rw_old), .alloc_tag_ROB(alloc_tag_ROB),
    .wb_valid(wb_valid), .wb_tag_ROB(wb_tag_ROB), .wb_tag_PRF(wb_tag_PRF), .wb_exc(wb_exc),
    .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_RegWr(retire_RegWr),
    .retire_Rw(retire_Rw), .retire_tag_PRF(retire_tag_PRF), .retire_tag_Rw_old(retire_tag_Rw_old),
    .flush_in(flush_in), .flush_out(flush_out), .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic [ARF_W-1:0] rw;
    logic             rg;
    logic [PRF_W-1:0] old;
  } ent_t;

  typedef struct {
    logic [ARF_W-1:0] rw;
    logic             rg;
    logic [PRF_W-1:0] old;
    logic [IW:0]      exp_count;
    logic [IW-1:0]    exp_tag;
  } vec_t;

  ent_t             sb[$];
  logic [PRF_W-1:0] mprf [DEPTH];
  logic [IW-1:0]    mhead, mtail;
  vec_t             tbl [DEPTH];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_in();
    alloc_valid = 1'b0; alloc_RegWr = 1'b0; alloc_Rw = '0; alloc_tag_Rw_old = '0;
    wb_valid = '0; wb_exc = '0; wb_tag_ROB = '0; wb_tag_PRF = '0; flush_in = 1'b0;
  endtask

  task automatic alloc(input int rw, input bit rg, input int old);
    alloc_valid = 1'b1; alloc_Rw = ARF_W'(rw); alloc_RegWr = rg; alloc_tag_Rw_old = PRF_W'(old);
  endtask

  // upd: the bench expects this writeback to land, so record the result tag
  task automatic wb(input int port, input int idx, input int tag, input bit e, input bit upd);
    wb_valid[port] = 1'b1;
    wb_exc[port]   = e;
    wb_tag_ROB[port*IW +: IW]       = IW'(idx);
    wb_tag_PRF[port*PRF_W +: PRF_W] = PRF_W'(tag);
    if (upd) mprf[idx] = PRF_W'(tag);
  endtask

  // One cycle: score a retire / allocation that the coming edge performs, then advance
  task automatic tick();
    ent_t e;
    bit   do_ret, do_al, fl;
    #1;
    fl     = flush_in;
    do_ret = retire_valid && retire_ready && !fl;
    do_al  = alloc_valid && (sb.size() < DEPTH) && !fl;
    if (do_ret) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("ret_Rw", retire_Rw, e.rw);
        chk("ret_RegWr", retire_RegWr, e.rg);
        chk("ret_old", retire_tag_Rw_old, e.old);
        chk("ret_prf", retire_tag_PRF, mprf[mhead]);
        mhead++;
      end
    end
    if (do_al) begin
      e.rw = alloc_Rw; e.rg = alloc_RegWr; e.old = alloc_tag_Rw_old;
      sb.push_back(e);
      mtail++;
    end
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete(); mhead = '0; mtail = '0;
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    retire_ready = 1'b1;
    mhead = '0; mtail = '0;
    for (int i = 0; i < DEPTH; i++) mprf[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i].rw        = ARF_W'((i + 1) % 8);
      tbl[i].rg        = (i % 3) != 0;
      tbl[i].old       = PRF_W'(i + 8);
      tbl[i].exp_count = (IW+1)'(i);
      tbl[i].exp_tag   = IW'(i);
    end

    // Reset state
    rst = 1'b0;
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag_ROB, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_retire_fields", {retire_RegWr, retire_Rw, retire_tag_PRF, retire_tag_Rw_old}, 0);
    chk("rst_flush_out", flush_out, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill all 16 entries from the table
    for (int i = 0; i < DEPTH; i++) begin
      alloc(tbl[i].rw, tbl[i].rg, tbl[i].old);
      chk("fill_tag", alloc_tag_ROB, tbl[i].exp_tag);
      chk("fill_count", count, tbl[i].exp_count);
      chk("fill_ready", alloc_ready, 1);
      tick();
    end
    chk("full_flag", full, 1);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    chk("full_tag", alloc_tag_ROB, 0);
    chk("full_empty", empty, 0);
    chk("full_rv", retire_valid, 0);

    // Complete 3,2,1,0 out of order; retire in order
    wb(0, 3, 20, 0, 1); wb(1, 2, 21, 0, 1);
    chk("ooo_rv0", retire_valid, 0);
    tick();
    wb(0, 1, 22, 0, 1); wb(1, 0, 23, 0, 1);
    chk("ooo_rv1", retire_valid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("ooo_rv", retire_valid, 1);
      chk("ooo_count", count, 16 - k);
      if (k == 0) begin
        alloc(5, 1, 5);
        chk("nobypass_ready", alloc_ready, 0);
      end
      tick();
    end
    chk("ooo_after_count", count, 12);
    chk("ooo_after_rv", retire_valid, 0);

    // Back-pressure holds the head
    retire_ready = 1'b0;
    wb(0, 4, 5, 0, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_rv", retire_valid, 1);
      chk("hold_count", count, 12);
      chk("hold_prf", retire_tag_PRF, 5);
      tick();
    end
    retire_ready = 1'b1;
    tick();
    chk("release_count", count, 11);

    // External flush; allocation in the flush cycle is dropped
    flush_in = 1'b1;
    alloc(1, 1, 1);
    tick();
    chk("flushin_empty", empty, 1);
    chk("flushin_count", count, 0);
    chk("flushin_fo", flush_out, 0);
    chk("flushin_tag", alloc_tag_ROB, 0);

    // Exception on entry 2 of 4
    for (int i = 0; i < 4; i++) begin
      alloc(i, 1, i + 1);
      tick();
    end
    wb(0, 0, 10, 0, 1); wb(1, 1, 11, 0, 1);
    tick();
    wb(0, 2, 12, 1, 0);
    chk("exc_rv0", retire_valid, 1);
    tick();
    chk("exc_rv1", retire_valid, 1);
    tick();
    chk("exc_head_rv", retire_valid, 0);
    chk("exc_head_count", count, 2);
    chk("exc_head_fo", flush_out, 0);
    tick();
    chk("exc_fo", flush_out, 1);
    chk("exc_count", count, 0);
    chk("exc_empty", empty, 1);
    chk("exc_tag", alloc_tag_ROB, 0);
    sb.delete(); mhead = '0; mtail = '0;
    tick();
    chk("exc_fo_pulse", flush_out, 0);

    // Streaming at occupancy 8 across several wraps
    retire_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alloc(i, i % 2, 20 + i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      wb(0, 2 * i, 2 * i, 0, 1); wb(1, 2 * i + 1, 2 * i + 1, 0, 1);
      tick();
    end
    retire_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      alloc(t % 8, t % 2, (t + 3) % 32);
      wb(0, (int'(mtail) + 15) % 16, (t + 9) % 32, 0, 1);
      chk("stream_count", count, 8);
      chk("stream_full", full, 0);
      chk("stream_empty", empty, 0);
      chk("stream_rv", retire_valid, 1);
      chk("stream_tag", alloc_tag_ROB, mtail);
      tick();
    end

    // Flush mid-stream
    flush_in = 1'b1;
    tick();
    chk("midflush_empty", empty, 1);
    chk("midflush_count", count, 0);
    chk("midflush_fo", flush_out, 0);

    // Two ports hit entry 5 in one cycle: port 1 tag wins
    retire_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      alloc(i, 1, 10 + i);
      tick();
    end
    wb(0, 5, 7, 0, 1); wb(1, 5, 9, 0, 1);
    tick();
    wb(0, 0, 1, 0, 1); wb(1, 1, 2, 0, 1);
    tick();
    wb(0, 2, 3, 0, 1); wb(1, 3, 4, 0, 1);
    tick();
    wb(0, 4, 6, 0, 1);
    tick();
    retire_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("dual_rv", retire_valid, 1);
      if (k == 5) chk("dual_prf", retire_tag_PRF, 9);
      tick();
    end
    chk("dual_empty", empty, 1);

    // Writeback in the allocation cycle is ignored; earliest retire two cycles later
    alloc(2, 1, 30);
    wb(0, 6, 13, 0, 0);
    tick();
    chk("early_rv0", retire_valid, 0);
    chk("early_count", count, 1);
    wb(0, 6, 17, 0, 1);
    tick();
    chk("early_rv1", retire_valid, 1);
    chk("early_prf", retire_tag_PRF, 17);
    tick();
    chk("early_empty", empty, 1);

    // Asynchronous reset with entries present
    alloc(3, 1, 3);
    tick();
    alloc(4, 0, 4);
    tick();
    chk("prerst_count", count, 2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_tag", alloc_tag_ROB, 0);
    chk("async_rst_rv", retire_valid, 0);
    sb.delete(); mhead = '0; mtail = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
